// File: rtl/muldiv_seq_unit.sv
// Sequential RV32M/RV64M multiply/divide unit: shift-add multiplier, restoring divider.
// Optional build macro MULDIV_FAST_MUL_EN selects a two-cycle full-width multiplier.
module muldiv_seq_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       OP,
    input  logic [XLEN-1:0]  DATA1,
    input  logic [XLEN-1:0]  DATA2,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  RESULT,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             BUSY
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              res_neg;
    logic [TAG_W-1:0]  tag_q;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic              out_valid_q;
    logic [XLEN-1:0]   result_q;
    logic [TAG_W-1:0]  out_tag_q;

    logic              sgn_a, sgn_b, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   a_mag, b_mag, early_res;
    logic              div0, ovf;
    logic [XLEN:0]     div_trial, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_step, prod, prod_s;
    logic [XLEN-1:0]   quo, rem, final_res;
`ifndef MULDIV_FAST_MUL_EN
    logic [XLEN:0]     mul_sum;
`endif

    assign IN_READY  = (state == IDLE) && !RESET;
    assign BUSY      = (state != IDLE);
    assign OUT_VALID = out_valid_q;
    assign RESULT    = result_q;
    assign OUT_TAG   = out_tag_q;

    // Operand decode at accept: magnitudes, result sign and divide early-outs.
    always_comb begin
        sgn_a     = (OP == 3'b001) || (OP == 3'b010) || (OP == 3'b100) || (OP == 3'b110);
        sgn_b     = (OP == 3'b001) || (OP == 3'b100) || (OP == 3'b110);
        a_neg     = sgn_a && DATA1[XLEN-1];
        b_neg     = sgn_b && DATA2[XLEN-1];
        a_mag     = a_neg ? -DATA1 : DATA1;
        b_mag     = b_neg ? -DATA2 : DATA2;
        neg_in    = (OP == 3'b110) ? a_neg : (a_neg ^ b_neg);
        div0      = OP[2] && (DATA2 == '0);
        ovf       = OP[2] && !OP[0] && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
        early_res = '0;
        if (div0)
            early_res = OP[1] ? DATA1 : '1;
        else if (!OP[1])
            early_res = DATA1;
    end

    // One iteration step; acc holds {product_hi, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_trial - {1'b0, mag_b};
        div_ge    = (div_trial >= {1'b0, mag_b});
`ifdef MULDIV_FAST_MUL_EN
        if (op_q[2])
            acc_step = {div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0], acc[XLEN-2:0], div_ge};
        else
            acc_step = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
        prod = acc;
`else
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
        if (op_q[2])
            acc_step = {div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0], acc[XLEN-2:0], div_ge};
        else
            acc_step = {mul_sum, acc[XLEN-1:1]};
        prod = acc_step;
`endif
        prod_s = res_neg ? -prod : prod;
        quo    = acc_step[XLEN-1:0];
        rem    = acc_step[2*XLEN-1:XLEN];
        if (op_q[2])
            final_res = op_q[1] ? (res_neg ? -rem : rem) : (res_neg ? -quo : quo);
        else
            final_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            op_q        <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            res_neg     <= 1'b0;
            tag_q       <= '0;
            cnt         <= '0;
            acc         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_tag_q   <= '0;
        end else if (FLUSH) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        op_q    <= OP;
                        mag_a   <= a_mag;
                        mag_b   <= b_mag;
                        res_neg <= neg_in;
                        tag_q   <= IN_TAG;
                        if (div0 || ovf) begin
                            state     <= DONE;
                            result_q  <= early_res;
                            out_tag_q <= IN_TAG;
                        end else begin
                            state <= CALC;
                            acc   <= OP[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
`ifdef MULDIV_FAST_MUL_EN
                            cnt   <= OP[2] ? CNT_W'(XLEN-1) : CNT_W'(1);
`else
                            cnt   <= CNT_W'(XLEN-1);
`endif
                        end
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= final_res;
                        out_tag_q   <= tag_q;
                    end
                end
                DONE: begin
                    // Early-out enters DONE with OUT_VALID low; it rises one edge later.
                    if (out_valid_q && OUT_READY) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed self-checking bench for muldiv_seq_unit at XLEN=32.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_seq_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FLUSH = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [2:0]  OP = '0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic [4:0]  IN_TAG = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] RESULT;
    logic [4:0]  OUT_TAG;
    logic        BUSY;

    int errors = 0;
    int checks = 0;

    muldiv_seq_unit #(.XLEN(32), .TAG_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OP(OP), .DATA1(DATA1), .DATA2(DATA2), .IN_TAG(IN_TAG),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .RESULT(RESULT), .OUT_TAG(OUT_TAG), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Present an operation and return just after its accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        int n;
        @(negedge CLK);
        OP = op; DATA1 = a; DATA2 = b; IN_TAG = tag; IN_VALID = 1'b1;
        n = 0;
        while (!IN_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    // Issue, wait for OUT_VALID counting edges after accept, then complete the handshake.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output logic [31:0] res,
                         output logic [4:0] otag, output int lat);
        issue(op, a, b, tag);
        lat = 0;
        while (!OUT_VALID && lat < 200) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        if (lat >= 200) lat = -1;
        res  = RESULT;
        otag = OUT_TAG;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({IN_READY, OUT_VALID, BUSY} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got ready/valid/busy=%b want 000", {IN_READY, OUT_VALID, BUSY});
        end
        checks++;
        if (RESULT !== 32'h0 || OUT_TAG !== 5'h0) begin
            errors++;
            $display("FAIL reset_data: got result=%h tag=%h want 0/0", RESULT, OUT_TAG);
        end
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", IN_READY);
        end
    endtask

    task automatic test_mul();
        logic [31:0] r; logic [4:0] t; int lat;
        do_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd9, r, t, lat);
        checks++;
        if (r !== 32'hFFFFFFEB) begin
            errors++; $display("FAIL mul_result: got %h want FFFFFFEB", r);
        end
        checks++;
        if (t !== 5'd9) begin
            errors++; $display("FAIL mul_tag: got %0d want 9", t);
        end
        checks++;
        if (lat !== MUL_LAT) begin
            errors++; $display("FAIL mul_latency: got %0d want %0d", lat, MUL_LAT);
        end
    endtask

    task automatic test_mulh();
        logic [2:0]  ops [3] = '{3'b001, 3'b010, 3'b011};
        logic [31:0] as  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [3] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
        logic [31:0] r; logic [4:0] t; int lat;
        for (int unsigned i = 0; i < 3; i++) begin
            do_op(ops[i], as[i], as[i], 5'(i + 1), r, t, lat);
            checks++;
            if (r !== exp[i] || t !== 5'(i + 1) || lat !== MUL_LAT) begin
                errors++;
                $display("FAIL mulh_op%0d: got result=%h tag=%0d lat=%0d want %h/%0d/%0d",
                         ops[i], r, t, lat, exp[i], i + 1, MUL_LAT);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001};
        logic [31:0] r; logic [4:0] t; int lat;
        for (int unsigned i = 0; i < 4; i++) begin
            do_op(ops[i], 32'hFFFFFFF9, 32'd2, 5'(i + 10), r, t, lat);
            checks++;
            if (r !== exp[i] || t !== 5'(i + 10) || lat !== DIV_LAT) begin
                errors++;
                $display("FAIL div_op%0d: got result=%h tag=%0d lat=%0d want %h/%0d/%0d",
                         ops[i], r, t, lat, exp[i], i + 10, DIV_LAT);
            end
        end
    endtask

    task automatic test_corner();
        logic [2:0]  ops [4] = '{3'b100, 3'b111, 3'b100, 3'b110};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        logic [31:0] r; logic [4:0] t; int lat;
        for (int unsigned i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], 5'(i + 20), r, t, lat);
            checks++;
            if (r !== exp[i] || t !== 5'(i + 20) || lat !== 1) begin
                errors++;
                $display("FAIL corner%0d: got result=%h tag=%0d lat=%0d want %h/%0d/1",
                         i, r, t, lat, exp[i], i + 20);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        bit bad;
        issue(3'b101, 32'd100, 32'd7, 5'd3);
        n = 0;
        while (!OUT_VALID && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checks++;
        if (OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL bp_valid: got %b want 1 within 200 cycles", OUT_VALID);
        end
        bad = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            if (RESULT !== 32'd14 || OUT_TAG !== 5'd3 || IN_READY !== 1'b0 ||
                BUSY !== 1'b1 || OUT_VALID !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold: got result=%h tag=%0d ready=%b busy=%b valid=%b want 0000000e/3/0/1/1",
                     RESULT, OUT_TAG, IN_READY, BUSY, OUT_VALID);
        end
        OUT_READY = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b0) begin
            errors++; $display("FAIL bp_no_reaccept: got ready=%b want 0", IN_READY);
        end
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        checks++;
        if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b busy=%b want 0/1/0", OUT_VALID, IN_READY, BUSY);
        end
    endtask

    task automatic test_flush();
        logic [31:0] r; logic [4:0] t; int lat;
        bit seen;
        issue(3'b100, 32'd1000, 32'd3, 5'd4);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        FLUSH = 1'b0;
        checks++;
        if (IN_READY !== 1'b1 || BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got ready=%b busy=%b valid=%b want 1/0/0", IN_READY, BUSY, OUT_VALID);
        end
        checks++;
        if (RESULT !== 32'd14 || OUT_TAG !== 5'd3) begin
            errors++; $display("FAIL flush_keep: got result=%h tag=%0d want 0000000e/3", RESULT, OUT_TAG);
        end
        seen = 1'b0;
        for (int unsigned i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (OUT_VALID) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL flush_no_valid: got valid=1 want 0");
        end
        // Flush together with an accept discards the operation.
        @(negedge CLK);
        OP = 3'b000; DATA1 = 32'd2; DATA2 = 32'd2; IN_TAG = 5'd6; IN_VALID = 1'b1; FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0; FLUSH = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || IN_READY !== 1'b1) begin
            errors++; $display("FAIL flush_accept: got busy=%b ready=%b want 0/1", BUSY, IN_READY);
        end
        do_op(3'b000, 32'd3, 32'd4, 5'd7, r, t, lat);
        checks++;
        if (r !== 32'd12 || t !== 5'd7 || lat !== MUL_LAT) begin
            errors++;
            $display("FAIL flush_next_mul: got result=%h tag=%0d lat=%0d want 0000000c/7/%0d", r, t, lat, MUL_LAT);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic [4:0] t; int lat;
        issue(3'b100, 32'd1000, 32'd3, 5'd5);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if ({OUT_VALID, BUSY, IN_READY} !== 3'b000 || RESULT !== 32'h0 || OUT_TAG !== 5'h0) begin
            errors++;
            $display("FAIL reset_mid: got valid/busy/ready=%b result=%h tag=%0d want 000/0/0",
                     {OUT_VALID, BUSY, IN_READY}, RESULT, OUT_TAG);
        end
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        do_op(3'b000, 32'd3, 32'd4, 5'd8, r, t, lat);
        checks++;
        if (r !== 32'd12 || t !== 5'd8 || lat !== MUL_LAT) begin
            errors++;
            $display("FAIL reset_next_mul: got result=%h tag=%0d lat=%0d want 0000000c/8/%0d", r, t, lat, MUL_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_corner();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
